// File: rtl/palette_lookup_pkg.sv
// Shared definitions for the palette lookup pipeline.
// Holds the RGB field layout inside a palette word, the channel width and the
// pixel entry that travels through the output queue (colour plus sideband).
package palette_lookup_pkg;

  localparam int unsigned IDX_W = 8;   // palette index width
  localparam int unsigned PAL_W = 16;  // palette RAM word width
  localparam int unsigned RGB_W = 12;  // packed colour width
  localparam int unsigned CH_W  = 4;   // width of one colour channel
  localparam int unsigned R_LSB = 8;   // red field offset
  localparam int unsigned G_LSB = 4;   // green field offset
  localparam int unsigned B_LSB = 0;   // blue field offset

  typedef struct packed {
    logic [RGB_W-1:0] rgb;
    logic             de;
    logic             hsync;
    logic             vsync;
  } pix_entry_t;

  // Extract one colour channel from a packed RGB value.
  function automatic logic [CH_W-1:0] rgb_chan(input logic [RGB_W-1:0] rgb,
                                               input int unsigned lsb);
    return rgb[lsb +: CH_W];
  endfunction

endpackage

// File: rtl/palette_lookup_pix_out_fifo.sv
// pix_out_fifo: registered-output queue of pixel entries.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i          write push_data_i this cycle (caller guarantees not full)
//   push_data_i     entry to enqueue
//   pop_i           consumer accepts the head (ignored while empty)
//   valid_o         head entry present (registered)
//   data_o          head entry (registered, '0 while empty)
//   count_o         number of queued entries, head included
module pix_out_fifo
  import palette_lookup_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  pix_entry_t    push_data_i,
  input  logic          pop_i,
  output logic          valid_o,
  output pix_entry_t    data_o,
  output logic [CW-1:0] count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  pix_entry_t    mem [DEPTH];
  logic [PW-1:0] rd_q, wr_q, rd_n, wr_n;
  logic [CW-1:0] count_q, count_n, remain;
  logic          valid_q, valid_n;
  pix_entry_t    data_q, data_n;
  logic          do_pop, do_push;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // The output register is loaded with the entry that will be at the head
  // after this cycle's push/pop, so data_o/valid_o come straight from flops.
  always_comb begin
    do_pop  = pop_i && valid_q;
    do_push = push_i;
    remain  = count_q - CW'(do_pop);
    count_n = remain + CW'(do_push);
    rd_n    = do_pop  ? wrap_inc(rd_q) : rd_q;
    wr_n    = do_push ? wrap_inc(wr_q) : wr_q;
    valid_n = (count_n != '0);
    data_n  = '0;
    if (do_push && (remain == '0)) begin
      data_n = push_data_i;   // queue drains to empty: the new entry is the head
    end else if (valid_n) begin
      data_n = mem[rd_n];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      rd_q    <= rd_n;
      wr_q    <= wr_n;
      count_q <= count_n;
      valid_q <= valid_n;
      data_q  <= data_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(push_i && (count_q == CW'(DEPTH))));
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign count_o = count_q;

endmodule

// File: rtl/palette_lookup.sv
// palette_lookup: indexed-colour to RGB444 conversion stage.
// An accepted pixel index is sent to an external synchronous palette RAM; one
// cycle later the returned colour (or BLANK_RGB when de is low) is queued
// together with its de/hsync/vsync and presented downstream via valid/ready.
// Ports:
//   clk_i, rst_ni                       clock, asynchronous active-low reset
//   pix_valid_i/pix_ready_o             upstream handshake
//   pix_index_i, pix_de_i/hsync/vsync   upstream pixel and sideband
//   pal_rd_en_o, pal_rd_addr_o          palette RAM read port
//   pal_rd_data_i                       palette word, one cycle after read
//   rgb_valid_o/rgb_ready_i             downstream handshake
//   rgb_r_o/g/b, de_o/hsync_o/vsync_o   downstream colour and sideband
//   underrun_o, underrun_clr_i          sticky underrun flag and its clear
module palette_lookup
  import palette_lookup_pkg::*;
#(
  parameter int unsigned      OUT_DEPTH = 2,
  parameter logic [RGB_W-1:0] BLANK_RGB = 12'h000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             pix_valid_i,
  output logic             pix_ready_o,
  input  logic [IDX_W-1:0] pix_index_i,
  input  logic             pix_de_i,
  input  logic             pix_hsync_i,
  input  logic             pix_vsync_i,
  output logic             pal_rd_en_o,
  output logic [IDX_W-1:0] pal_rd_addr_o,
  input  logic [PAL_W-1:0] pal_rd_data_i,
  output logic             rgb_valid_o,
  input  logic             rgb_ready_i,
  output logic [CH_W-1:0]  rgb_r_o,
  output logic [CH_W-1:0]  rgb_g_o,
  output logic [CH_W-1:0]  rgb_b_o,
  output logic             de_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             underrun_o,
  input  logic             underrun_clr_i
);

  localparam int unsigned CW = $clog2(OUT_DEPTH + 1);

  logic          run_q;        // low during reset and the first cycle after it
  logic          inflight_q;   // a palette read is outstanding
  logic          cap_de_q, cap_hsync_q, cap_vsync_q;
  logic          armed_q;
  logic          underrun_q;
  logic          accept;
  logic [CW:0]   occupancy;
  logic [CW-1:0] fifo_count;
  pix_entry_t    push_entry;
  pix_entry_t    head;

  // Ready looks only at registered state so rgb_ready_i never reaches it.
  always_comb begin
    occupancy   = {1'b0, fifo_count} + (CW + 1)'(inflight_q);
    pix_ready_o = run_q && (occupancy < (CW + 1)'(OUT_DEPTH));
    accept      = pix_valid_i && pix_ready_o;
  end

  assign pal_rd_en_o   = accept && pix_de_i;
  assign pal_rd_addr_o = pix_index_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q       <= 1'b0;
      inflight_q  <= 1'b0;
      cap_de_q    <= 1'b0;
      cap_hsync_q <= 1'b0;
      cap_vsync_q <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      inflight_q <= accept;
      if (accept) begin
        cap_de_q    <= pix_de_i;
        cap_hsync_q <= pix_hsync_i;
        cap_vsync_q <= pix_vsync_i;
      end
    end
  end

  always_comb begin
    push_entry.rgb   = cap_de_q ? pal_rd_data_i[RGB_W-1:0] : BLANK_RGB;
    push_entry.de    = cap_de_q;
    push_entry.hsync = cap_hsync_q;
    push_entry.vsync = cap_vsync_q;
  end

  pix_out_fifo #(
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (inflight_q),
    .push_data_i (push_entry),
    .pop_i       (rgb_ready_i),
    .valid_o     (rgb_valid_o),
    .data_o      (head),
    .count_o     (fifo_count)
  );

  assign rgb_r_o = rgb_chan(head.rgb, R_LSB);
  assign rgb_g_o = rgb_chan(head.rgb, G_LSB);
  assign rgb_b_o = rgb_chan(head.rgb, B_LSB);
  assign de_o    = head.de;
  assign hsync_o = head.hsync;
  assign vsync_o = head.vsync;

  // Setting wins over a coincident clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      armed_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      if (accept) begin
        armed_q <= 1'b1;
      end
      if (armed_q && rgb_ready_i && !rgb_valid_o) begin
        underrun_q <= 1'b1;
      end else if (underrun_clr_i) begin
        underrun_q <= 1'b0;
      end
    end
  end

  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_palette_lookup.sv
module tb_palette_lookup;
  import palette_lookup_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam logic [11:0] BLANK = 12'h5A3;

  logic clk = 1'b0;
  logic rst_ni = 1'b1;
  logic pix_valid_i = 1'b0, pix_ready_o;
  logic [7:0] pix_index_i = '0;
  logic pix_de_i = 1'b0, pix_hsync_i = 1'b0, pix_vsync_i = 1'b0;
  logic pal_rd_en_o;
  logic [7:0] pal_rd_addr_o;
  logic [15:0] pal_rd_data_i = '0;
  logic rgb_valid_o, rgb_ready_i = 1'b0;
  logic [3:0] rgb_r_o, rgb_g_o, rgb_b_o;
  logic de_o, hsync_o, vsync_o, underrun_o, underrun_clr_i = 1'b0;

  palette_lookup #(
    .OUT_DEPTH (DEPTH),
    .BLANK_RGB (BLANK)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .pix_valid_i    (pix_valid_i),
    .pix_ready_o    (pix_ready_o),
    .pix_index_i    (pix_index_i),
    .pix_de_i       (pix_de_i),
    .pix_hsync_i    (pix_hsync_i),
    .pix_vsync_i    (pix_vsync_i),
    .pal_rd_en_o    (pal_rd_en_o),
    .pal_rd_addr_o  (pal_rd_addr_o),
    .pal_rd_data_i  (pal_rd_data_i),
    .rgb_valid_o    (rgb_valid_o),
    .rgb_ready_i    (rgb_ready_i),
    .rgb_r_o        (rgb_r_o),
    .rgb_g_o        (rgb_g_o),
    .rgb_b_o        (rgb_b_o),
    .de_o           (de_o),
    .hsync_o        (hsync_o),
    .vsync_o        (vsync_o),
    .underrun_o     (underrun_o),
    .underrun_clr_i (underrun_clr_i)
  );

  always #5 clk = ~clk;

  // Synchronous palette RAM; junk on cycles without a read.
  logic [15:0] pal_mem [256];
  always @(posedge clk) begin
    if (pal_rd_en_o) pal_rd_data_i <= pal_mem[pal_rd_addr_o];
    else             pal_rd_data_i <= 16'($urandom);
  end

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int accepts = 0;
  int stalls  = 0;
  bit mon_en  = 1'b0;
  pix_entry_t sb[$];
  int pop_cyc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] out_word();
    return {rgb_r_o, rgb_g_o, rgb_b_o, de_o, hsync_o, vsync_o};
  endfunction

  // Monitor / scoreboard, sampled mid-cycle.
  logic        prev_hold = 1'b0;
  logic [14:0] prev_out  = '0;
  always @(negedge clk) begin
    pix_entry_t e;
    cycle++;
    if (!rst_ni) begin
      sb.delete();
      prev_hold = 1'b0;
    end else begin
      if (mon_en)
        check("ready_occupancy", 32'(pix_ready_o), 32'(sb.size() < DEPTH));
      check("rd_en", 32'(pal_rd_en_o), 32'(pix_valid_i && pix_ready_o && pix_de_i));
      if (pal_rd_en_o) check("rd_addr", 32'(pal_rd_addr_o), 32'(pix_index_i));
      if (prev_hold) check("hold_stable", 32'(out_word()), 32'(prev_out));
      if (rgb_valid_o && rgb_ready_i) begin
        if (sb.size() == 0) check("unexpected_out", 32'(rgb_valid_o), 32'(0));
        else begin
          e = sb.pop_front();
          check("pixel", 32'(out_word()), 32'(e));
          pop_cyc.push_back(cycle);
        end
      end
      if (pix_valid_i && pix_ready_o) begin
        e.rgb   = pix_de_i ? pal_mem[pix_index_i][11:0] : BLANK;
        e.de    = pix_de_i;
        e.hsync = pix_hsync_i;
        e.vsync = pix_vsync_i;
        sb.push_back(e);
        accepts++;
      end
      prev_hold = rgb_valid_o && !rgb_ready_i;
      prev_out  = out_word();
    end
  end

  task automatic send(input logic [7:0] idx, input logic de, input logic hs, input logic vs);
    bit done = 1'b0;
    @(posedge clk); #1;
    pix_valid_i = 1'b1; pix_index_i = idx;
    pix_de_i = de; pix_hsync_i = hs; pix_vsync_i = vs;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (pix_ready_o) begin done = 1'b1; break; end
      stalls++;
    end
    if (!done) check("send_timeout", 32'(pix_ready_o), 32'(1));
  endtask

  task automatic idle();
    @(posedge clk); #1;
    pix_valid_i = 1'b0; pix_de_i = 1'b0; pix_hsync_i = 1'b0; pix_vsync_i = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 300; k++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check("drain_empty", 32'(sb.size()), 32'(0));
  endtask

  initial begin
    int acc0;
    int valid_seen;
    for (int i = 0; i < 256; i++) pal_mem[i] = 16'($urandom);
    pal_mem[5] = 16'h0F80;

    #1 rst_ni = 1'b0;
    cycles(3);
    check("rst_ready", 32'(pix_ready_o), 32'(0));
    check("rst_valid", 32'(rgb_valid_o), 32'(0));
    check("rst_underrun", 32'(underrun_o), 32'(0));
    check("rst_outputs", 32'(out_word()), 32'(0));
    rst_ni = 1'b1;
    #1 check("ready_before_edge", 32'(pix_ready_o), 32'(0));
    cycles(1);
    check("ready_after_release", 32'(pix_ready_o), 32'(1));
    mon_en = 1'b1;

    // No underrun before the first accept.
    rgb_ready_i = 1'b1;
    cycles(6);
    check("underrun_unarmed", 32'(underrun_o), 32'(0));

    // Two-cycle latency into an empty pipe.
    rgb_ready_i = 1'b0;
    send(8'h05, 1'b1, 1'b0, 1'b0);
    idle();
    check("latency_c1", 32'(rgb_valid_o), 32'(0));
    cycles(1);
    check("latency_c2", 32'(rgb_valid_o), 32'(1));
    check("rgb_0f80", 32'({rgb_r_o, rgb_g_o, rgb_b_o}), 32'(12'hF80));
    check("de_out", 32'(de_o), 32'(1));
    rgb_ready_i = 1'b1;
    drain();

    // Blanked pixel keeps its sync.
    send(8'h05, 1'b0, 1'b1, 1'b0);
    idle();
    cycles(1);
    check("blank_valid", 32'(rgb_valid_o), 32'(1));
    check("blank_rgb", 32'({rgb_r_o, rgb_g_o, rgb_b_o}), 32'(BLANK));
    check("blank_hsync", 32'(hsync_o), 32'(1));
    drain();

    // 256 back-to-back indices.
    stalls = 0;
    pop_cyc.delete();
    for (int i = 0; i < 256; i++) send(8'(i), 1'b1, 1'(i % 3 == 0), 1'(i == 0));
    idle();
    drain();
    check("stream_stalls", 32'(stalls), 32'(0));
    check("stream_count", 32'(pop_cyc.size()), 32'(256));
    if (pop_cyc.size() == 256)
      check("stream_rate", 32'(pop_cyc[255] - pop_cyc[0]), 32'(255));

    // Backpressure for 10 cycles while streaming.
    rgb_ready_i = 1'b0;
    acc0 = accepts;
    fork
      begin
        for (int i = 0; i < 12; i++)
          send(8'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom));
        idle();
      end
      begin
        cycles(10);
        check("bp_accepts", 32'(accepts - acc0), 32'(DEPTH));
        check("bp_ready_low", 32'(pix_ready_o), 32'(0));
        rgb_ready_i = 1'b1;
      end
    join
    drain();
    check("bp_total", 32'(accepts - acc0), 32'(12));

    // Underrun set, clear, set-beats-clear.
    rgb_ready_i = 1'b0;
    underrun_clr_i = 1'b1;
    cycles(1);
    underrun_clr_i = 1'b0;
    check("underrun_cleared", 32'(underrun_o), 32'(0));
    rgb_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) send(8'(i + 16), 1'b1, 1'b0, 1'b0);
    idle();
    drain();
    cycles(2);
    check("underrun_set", 32'(underrun_o), 32'(1));
    underrun_clr_i = 1'b1;
    cycles(1);
    underrun_clr_i = 1'b0;
    check("underrun_set_wins", 32'(underrun_o), 32'(1));
    rgb_ready_i = 1'b0;
    underrun_clr_i = 1'b1;
    cycles(1);
    underrun_clr_i = 1'b0;
    check("underrun_clr_pulse", 32'(underrun_o), 32'(0));
    cycles(3);
    check("underrun_stays_clr", 32'(underrun_o), 32'(0));

    // Reset with the queue full.
    for (int i = 0; i < DEPTH; i++) send(8'(i + 40), 1'b1, 1'b1, 1'b1);
    idle();
    cycles(3);
    check("full_valid", 32'(rgb_valid_o), 32'(1));
    check("full_ready", 32'(pix_ready_o), 32'(0));
    mon_en = 1'b0;
    rst_ni = 1'b0;
    #1;
    check("midrst_valid", 32'(rgb_valid_o), 32'(0));
    check("midrst_ready", 32'(pix_ready_o), 32'(0));
    check("midrst_outputs", 32'(out_word()), 32'(0));
    cycles(2);
    rst_ni = 1'b1;
    rgb_ready_i = 1'b1;
    cycles(1);
    mon_en = 1'b1;
    valid_seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rgb_valid_o) valid_seen++;
    end
    check("no_stale_pixel", 32'(valid_seen), 32'(0));
    check("underrun_after_rst", 32'(underrun_o), 32'(0));

    for (int i = 0; i < 6; i++) send(8'(i * 37), 1'(i != 2), 1'b0, 1'(i == 5));
    idle();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    check("global_timeout", 32'(0), 32'(1));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "FAIL global_timeout");
  end

endmodule

// File: doc/palette_lookup.md
PALETTE_LOOKUP -- requirements
Module: palette_lookup

Interface
REQ-001 SHALL have parameter OUT_DEPTH, default 2, output FIFO depth in entries (legal 2..8).
REQ-002 SHALL have parameter BLANK_RGB, default 12'h000, RGB emitted when de is low.
REQ-003 clk_i  in  1  single clock; all logic on rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 pix_valid_i  in  1  upstream pixel valid.
REQ-006 pix_ready_o  out  1  upstream pixel accepted when valid&&ready.
REQ-007 pix_index_i  in  8  palette index.
REQ-008 pix_de_i / pix_hsync_i / pix_vsync_i  in  1 each  display-enable and syncs travelling with pixel.
REQ-009 pal_rd_en_o  out  1  palette RAM read enable.
REQ-010 pal_rd_addr_o  out  8  palette RAM read address.
REQ-011 pal_rd_data_i  in  16  palette RAM data, valid exactly 1 cycle after pal_rd_en_o; bits [11:8]=R, [7:4]=G, [3:0]=B, [15:12] ignored.
REQ-012 rgb_valid_o  out  1  downstream pixel valid.
REQ-013 rgb_ready_i  in  1  downstream accept.
REQ-014 rgb_r_o / rgb_g_o / rgb_b_o  out  4 each  colour.
REQ-015 de_o / hsync_o / vsync_o  out  1 each  delayed sideband.
REQ-016 underrun_o  out  1  sticky underrun flag.
REQ-017 underrun_clr_i  in  1  clears underrun_o.

Function
REQ-018 Accept = pix_valid_i && pix_ready_o; pal_rd_en_o SHALL equal Accept && pix_de_i, pal_rd_addr_o SHALL equal pix_index_i (combinational).
REQ-019 pix_ready_o SHALL be (fifo_count + inflight) < OUT_DEPTH from registered state only; no combinational path from rgb_ready_i.
REQ-020 inflight SHALL be a register set on Accept and cleared otherwise; accompanying de/hsync/vsync captured alongside.
REQ-021 Cycle after Accept SHALL push one entry: colour = pal_rd_data_i[11:0] if captured de=1, else BLANK_RGB; sideband = captured values.
REQ-022 Latency Accept -> rgb_valid_o SHALL be exactly 2 cycles when FIFO empty.
REQ-023 FIFO outputs SHALL be registered; pop on rgb_valid_o && rgb_ready_i; simultaneous push and pop SHALL leave count unchanged, order preserved.
REQ-024 Outputs SHALL hold stable while rgb_valid_o && !rgb_ready_i.
REQ-025 FIFO SHALL never overflow; push when full is impossible by REQ-019 (assertion).
REQ-026 Pointers SHALL wrap modulo OUT_DEPTH; count width clog2(OUT_DEPTH+1).
REQ-027 armed flag SHALL set on first Accept after reset; underrun_o SHALL set when armed && rgb_ready_i && !rgb_valid_o.
REQ-028 underrun_clr_i SHALL clear underrun_o next cycle; simultaneous set and clear SHALL leave it set.
REQ-029 Sustained throughput SHALL be 1 pixel/cycle with rgb_ready_i constantly high.

Reset
REQ-030 During reset: pix_ready_o, rgb_valid_o, inflight, armed, underrun_o, FIFO count = 0; colour and sideband outputs = 0.
REQ-031 pix_ready_o SHALL rise first cycle after deassertion; reset mid-stream SHALL discard in-flight and queued pixels.

Structure
REQ-032 Package palette_lookup_pkg SHALL hold RGB field offsets/widths and the pixel-entry struct (rgb[11:0], de, hsync, vsync).
REQ-033 One sub-module pix_out_fifo (registered-output, parameterised depth) SHALL implement the queue.

Verification
REQ-034 Palette mem[0x05]=16'h0F80, send index 0x05 de=1 into empty pipe -> rgb_valid_o at +2 cycles, R=F G=8 B=0.
REQ-035 Send index 0x05 with de=0, hsync=1 -> output RGB=BLANK_RGB, hsync_o=1, pal_rd_en_o stays 0.
REQ-036 256 back-to-back indices 0..255, rgb_ready_i=1 -> 256 outputs in order, one per cycle, matching palette.
REQ-037 Hold rgb_ready_i=0 for 10 cycles while streaming -> pix_ready_o falls after OUT_DEPTH accepts, no loss/duplication after release.
REQ-038 Stream 4 pixels, then valid low with rgb_ready_i=1 -> underrun_o=1; pulse underrun_clr_i -> 0; before any accept, never set.
REQ-039 Assert rst_ni low with FIFO full -> rgb_valid_o=0 immediately, no stale pixel after release.
